// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bus: ID-stage tags and WB branch outcome in,
// PC/IF/ID/ID-EX/EX-WB write and bubble controls out.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 6
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_uses_rs;
  logic                  id_uses_rt;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_writes_rd;
  logic                  id_is_branch;
  logic                  wb_taken;
  logic                  pc_write;
  logic                  ifid_write;
  logic                  ifid_flush;
  logic                  idex_bubble;
  logic                  exwb_bubble;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
    output id_rd, id_writes_rd, id_is_branch, wb_taken,
    input  pc_write, ifid_write, ifid_flush,
    input  idex_bubble, exwb_bubble
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
    input  id_rd, id_writes_rd, id_is_branch, wb_taken,
    output pc_write, ifid_write, ifid_flush,
    output idex_bubble, exwb_bubble
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Interlock/flush controller for the IF/ID/EX/WB pipeline.
// Ports: clock, reset (sync, active high), bus (slave modport: ID tags,
// wb_taken in; pc/ifid/idex/exwb controls out), stall_cnt, flush_cnt.
// Option: HAZARD_WB_BYPASS_EN ignores WB-slot dependencies.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W = 6,
  parameter int CNT_W      = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  pipeline_hazard_ctrl_if.slave  bus,
  output logic [CNT_W-1:0]       stall_cnt,
  output logic [CNT_W-1:0]       flush_cnt
);

  typedef enum logic [1:0] {
    S_RUN,
    S_STALL,
    S_FLUSH
  } state_t;

  state_t                r_state;
  state_t                w_next;

  logic                  r_ex_v;
  logic [REG_ADDR_W-1:0] r_ex_rd;
  logic                  r_ex_wr;
  logic                  r_ex_br;
  logic                  r_wb_v;
  logic [REG_ADDR_W-1:0] r_wb_rd;
  logic                  r_wb_wr;
  logic                  r_wb_br;

  logic [CNT_W-1:0]      r_stall_cnt;
  logic [CNT_W-1:0]      r_flush_cnt;

  logic                  w_flush;
  logic                  w_hz_ex;
  logic                  w_hz_wb;
  logic                  w_br_fly;
  logic                  w_hazard;

  assign w_flush = r_wb_v & r_wb_br & bus.wb_taken;

  assign w_hz_ex = r_ex_v & r_ex_wr &
    ((bus.id_uses_rs & (bus.id_rs == r_ex_rd)) |
     (bus.id_uses_rt & (bus.id_rt == r_ex_rd)));

`ifdef HAZARD_WB_BYPASS_EN
  // Register file writes before it reads: WB results are visible to ID.
  assign w_hz_wb = 1'b0;
`else
  assign w_hz_wb = r_wb_v & r_wb_wr &
    ((bus.id_uses_rs & (bus.id_rs == r_wb_rd)) |
     (bus.id_uses_rt & (bus.id_rt == r_wb_rd)));
`endif

  // Hold ID while a branch sits in EX so only one is ever unresolved.
  assign w_br_fly = r_ex_v & r_ex_br;

  assign w_hazard = bus.id_valid & (w_hz_ex | w_hz_wb | w_br_fly);

  always_comb begin
    w_next = S_RUN;
    if (w_flush)       w_next = S_FLUSH;
    else if (w_hazard) w_next = S_STALL;
  end

  always_comb begin
    bus.pc_write    = (w_next != S_STALL);
    bus.ifid_write  = (w_next != S_STALL);
    bus.ifid_flush  = (w_next == S_FLUSH);
    bus.idex_bubble = (w_next != S_RUN);
    bus.exwb_bubble = (w_next == S_FLUSH);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_RUN;
      r_ex_v      <= 1'b0;
      r_ex_rd     <= '0;
      r_ex_wr     <= 1'b0;
      r_ex_br     <= 1'b0;
      r_wb_v      <= 1'b0;
      r_wb_rd     <= '0;
      r_wb_wr     <= 1'b0;
      r_wb_br     <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_next;
      case (w_next)
        S_FLUSH: begin
          r_ex_v <= 1'b0;
          r_wb_v <= 1'b0;
        end
        S_STALL: begin
          r_ex_v  <= 1'b0;
          r_wb_v  <= r_ex_v;
          r_wb_rd <= r_ex_rd;
          r_wb_wr <= r_ex_wr;
          r_wb_br <= r_ex_br;
        end
        default: begin
          r_ex_v  <= bus.id_valid;
          r_ex_rd <= bus.id_rd;
          r_ex_wr <= bus.id_writes_rd;
          r_ex_br <= bus.id_is_branch;
          r_wb_v  <= r_ex_v;
          r_wb_rd <= r_ex_rd;
          r_wb_wr <= r_ex_wr;
          r_wb_br <= r_ex_br;
        end
      endcase
      // Counters follow the registered state, one cycle behind.
      if (r_state == S_STALL && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (r_state == S_FLUSH && r_flush_cnt != '1)
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed table,
// multi-cycle corner sequences and a random run against a slot model.
module tb_pipeline_hazard_ctrl;
  localparam int RW = 6;
`ifdef HAZARD_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam logic [4:0] O_RUN = 5'b11000;
  localparam logic [4:0] O_STL = 5'b00010;
  localparam logic [4:0] O_FLS = 5'b11111;

  typedef struct {
    logic       v;
    int         rs;
    logic       urs;
    int         rt;
    logic       urt;
    int         rd;
    logic       wr;
    logic       br;
    logic       tk;
    logic [4:0] exp;
  } vec_t;

  typedef struct {
    bit v;
    int rd;
    bit wr;
    bit br;
  } ins_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
  logic [3:0]  stall_cnt4;
  logic [3:0]  flush_cnt4;
  int          checks = 0;
  int          errors = 0;

  always #5 clock = ~clock;

  pipeline_hazard_ctrl_if #(.REG_ADDR_W(RW)) bus ();
  pipeline_hazard_ctrl_if #(.REG_ADDR_W(RW)) bus4 ();

  assign bus4.id_valid     = bus.id_valid;
  assign bus4.id_rs        = bus.id_rs;
  assign bus4.id_rt        = bus.id_rt;
  assign bus4.id_uses_rs   = bus.id_uses_rs;
  assign bus4.id_uses_rt   = bus.id_uses_rt;
  assign bus4.id_rd        = bus.id_rd;
  assign bus4.id_writes_rd = bus.id_writes_rd;
  assign bus4.id_is_branch = bus.id_is_branch;
  assign bus4.wb_taken     = bus.wb_taken;

  pipeline_hazard_ctrl #(.REG_ADDR_W(RW), .CNT_W(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus.slave),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  pipeline_hazard_ctrl #(.REG_ADDR_W(RW), .CNT_W(4)) dut4 (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus4.slave),
    .stall_cnt (stall_cnt4),
    .flush_cnt (flush_cnt4)
  );

  function automatic vec_t mk(logic v, int rs, logic urs, int rt,
                              logic urt, int rd, logic wr, logic br,
                              logic tk, logic [4:0] e);
    vec_t t;
    t.v = v; t.rs = rs; t.urs = urs; t.rt = rt; t.urt = urt;
    t.rd = rd; t.wr = wr; t.br = br; t.tk = tk; t.exp = e;
    return t;
  endfunction

  task automatic apply(input vec_t t);
    bus.id_valid     = t.v;
    bus.id_rs        = RW'(t.rs);
    bus.id_uses_rs   = t.urs;
    bus.id_rt        = RW'(t.rt);
    bus.id_uses_rt   = t.urt;
    bus.id_rd        = RW'(t.rd);
    bus.id_writes_rd = t.wr;
    bus.id_is_branch = t.br;
    bus.wb_taken     = t.tk;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [4:0] outs();
    return {bus.pc_write, bus.ifid_write, bus.ifid_flush,
            bus.idex_bubble, bus.exwb_bubble};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Reference: the two downstream slots as a tiny array, decisions
  // taken straight from the interlock/flush rules.
  ins_t pipe[2];
  int   m_stalls;
  int   m_flushes;

  function automatic bit dep(ins_t p, vec_t t);
    return p.v && p.wr &&
      ((t.urs && t.rs == p.rd) || (t.urt && t.rt == p.rd));
  endfunction

  function automatic logic [4:0] predict(vec_t t);
    bit fl;
    bit st;
    fl = pipe[1].v && pipe[1].br && t.tk;
    st = t.v && (dep(pipe[0], t) || (pipe[0].v && pipe[0].br) ||
                 (!BYP && dep(pipe[1], t)));
    if (fl) return O_FLS;
    if (st) return O_STL;
    return O_RUN;
  endfunction

  task automatic advance(input vec_t t, input logic [4:0] mode);
    ins_t e;
    e = '{v: 1'b0, rd: 0, wr: 1'b0, br: 1'b0};
    if (mode == O_FLS) begin
      m_flushes++;
      pipe[0] = e;
      pipe[1] = e;
    end else if (mode == O_STL) begin
      m_stalls++;
      pipe[1] = pipe[0];
      pipe[0] = e;
    end else begin
      pipe[1] = pipe[0];
      pipe[0] = t.v ? '{v: 1'b1, rd: t.rd, wr: t.wr, br: t.br} : e;
    end
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  vec_t tbl[30];
  vec_t idle;
  vec_t t;
  logic [4:0] o2;
  logic [4:0] ex;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN);
    o2 = BYP ? O_RUN : O_STL;
    tbl[0]  = mk(1, 0, 0, 0, 0, 5, 1, 0, 0, O_RUN);
    tbl[1]  = mk(1, 5, 1, 0, 0, 6, 0, 0, 0, O_STL);
    tbl[2]  = mk(1, 5, 1, 0, 0, 6, 0, 0, 0, o2);
    tbl[3]  = mk(1, 5, 1, 0, 0, 6, 0, 0, 0, O_RUN);
    tbl[4]  = idle;
    tbl[5]  = mk(1, 0, 0, 0, 0, 9, 1, 0, 0, O_RUN);
    tbl[6]  = mk(1, 0, 0, 0, 0, 10, 0, 0, 0, O_RUN);
    tbl[7]  = mk(1, 9, 0, 9, 1, 11, 0, 0, 0, o2);
    tbl[8]  = mk(1, 9, 0, 9, 1, 11, 0, 0, 0, O_RUN);
    tbl[9]  = idle;
    tbl[10] = mk(1, 0, 0, 0, 0, 12, 1, 0, 0, O_RUN);
    tbl[11] = mk(1, 12, 0, 12, 0, 13, 0, 0, 0, O_RUN);
    tbl[12] = idle;
    tbl[13] = idle;
    tbl[14] = mk(1, 0, 0, 0, 0, 3, 1, 0, 0, O_RUN);
    tbl[15] = mk(0, 3, 1, 3, 1, 0, 0, 0, 0, O_RUN);
    tbl[16] = idle;
    tbl[17] = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, O_RUN);
    tbl[18] = mk(1, 0, 0, 0, 0, 1, 1, 0, 0, O_STL);
    tbl[19] = mk(1, 0, 0, 0, 0, 1, 1, 0, 1, O_FLS);
    tbl[20] = idle;
    tbl[21] = mk(1, 0, 0, 0, 0, 7, 1, 1, 0, O_RUN);
    tbl[22] = mk(1, 7, 1, 0, 0, 8, 1, 0, 0, O_STL);
    tbl[23] = mk(1, 7, 1, 0, 0, 8, 1, 0, 1, O_FLS);
    tbl[24] = idle;
    tbl[25] = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, O_RUN);
    tbl[26] = mk(1, 0, 0, 0, 0, 2, 1, 0, 0, O_STL);
    tbl[27] = mk(1, 0, 0, 0, 0, 2, 1, 0, 0, O_RUN);
    tbl[28] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, O_RUN);
    tbl[29] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, O_RUN);

    reset = 1'b1;
    apply(idle);
    tick();
    tick();
    check("reset_outs", int'(outs()), int'(O_RUN));
    check("reset_stall_cnt", int'(stall_cnt), 0);
    check("reset_flush_cnt", int'(flush_cnt), 0);
    reset = 1'b0;

    for (int i = 0; i < 30; i++) begin
      apply(tbl[i]);
      #1;
      check($sformatf("tbl[%0d]", i), int'(outs()), int'(tbl[i].exp));
      tick();
    end
    apply(idle);
    repeat (3) tick();
    check("tbl_stall_cnt", int'(stall_cnt), BYP ? 4 : 6);
    check("tbl_flush_cnt", int'(flush_cnt), 2);

    // Reset in the middle of an interlock stall.
    apply(mk(1, 0, 0, 0, 0, 5, 1, 0, 0, O_RUN));
    tick();
    apply(mk(1, 5, 1, 0, 0, 6, 0, 0, 1, O_STL));
    #1;
    check("pre_reset_stall", int'(outs()), int'(O_STL));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("rst_stall_outs", int'(outs()), int'(O_RUN));
    check("rst_stall_cnt", int'(stall_cnt), 0);
    check("rst_flush_cnt", int'(flush_cnt), 0);
    tick();

    // Reset in the cycle a taken branch flushes.
    apply(idle);
    tick();
    apply(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, O_RUN));
    tick();
    apply(mk(1, 0, 0, 0, 0, 4, 1, 0, 0, O_STL));
    tick();
    apply(mk(1, 0, 0, 0, 0, 4, 1, 0, 1, O_FLS));
    #1;
    check("pre_reset_flush", int'(outs()), int'(O_FLS));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("rst_flush_outs", int'(outs()), int'(O_RUN));
    check("rst_flush_cnt2", int'(flush_cnt), 0);

    // Twenty dependency pairs: wide counter keeps counting, 4-bit sticks.
    do_reset();
    for (int p = 0; p < 20; p++) begin
      apply(mk(1, 0, 0, 0, 0, 5, 1, 0, 0, O_RUN));
      tick();
      apply(mk(1, 5, 1, 0, 0, 6, 0, 0, 0, O_RUN));
      repeat (3) tick();
      apply(idle);
      tick();
    end
    repeat (3) tick();
    check("sat_wide", int'(stall_cnt), BYP ? 20 : 40);
    check("sat_cnt4", int'(stall_cnt4), 15);
    check("sat_flush4", int'(flush_cnt4), 0);

    // Random traffic against the slot model.
    apply(idle);
    do_reset();
    pipe[0] = '{v: 1'b0, rd: 0, wr: 1'b0, br: 1'b0};
    pipe[1] = pipe[0];
    m_stalls = 0;
    m_flushes = 0;
    for (int c = 0; c < 400; c++) begin
      t = mk($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0,
             $urandom_range(0, 3) == 0, O_RUN);
      ex = predict(t);
      apply(t);
      #1;
      check($sformatf("rnd[%0d]", c), int'(outs()), int'(ex));
      advance(t, ex);
      tick();
    end
    apply(idle);
    repeat (3) tick();
    check("rnd_stall_cnt", int'(stall_cnt), m_stalls);
    check("rnd_flush_cnt", int'(flush_cnt), m_flushes);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Interlock and flush controller for the four-stage IF/ID/EX/WB pipeline. Keeps a shadow copy of the destination and branch tags held in the ID/EX and EX/WB buffers. Stalls the PC and IF/ID buffer on read-after-write hazards and squashes wrong-path instructions when a branch resolves taken in WB. Drives the write-enable and flush controls of the PC, IFIDBuff, IDEXbuff and EXWBbuff, and keeps saturating stall and flush counters for debug.

## Interface
Parameters:
- `REG_ADDR_W`, default 6: register specifier width. Matches rs/rt/rd fields [27:22], [21:16] and [15:10].
- `CNT_W`, default 16: width of each performance counter.

Ports:
- `clock`  in  1: single system clock, rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `id_valid`  in  1: IF/ID holds a real instruction.
- `id_rs`, `id_rt`  in  REG_ADDR_W: source specifiers of the ID instruction.
- `id_uses_rs`, `id_uses_rt`  in  1: the ID instruction reads rs / rt (from Control).
- `id_rd`  in  REG_ADDR_W: destination specifier of the ID instruction.
- `id_writes_rd`  in  1: the ID instruction writes the register file.
- `id_is_branch`  in  1: the ID instruction is a branch or jump.
- `wb_taken`  in  1: branch-taken term (OR of BZ/BN/jump terms) computed from EX/WB.
- `pc_write`  out  1: PC loads the pcmux output.
- `ifid_write`  out  1: IF/ID buffer captures.
- `ifid_flush`  out  1: IF/ID buffer loads a bubble.
- `idex_bubble`  out  1: ID/EX loads a bubble: EX/MEM controls and write-back zeroed.
- `exwb_bubble`  out  1: EX/WB loads a bubble.
- `stall_cnt`  out  CNT_W: cycles spent in interlock stall.
- `flush_cnt`  out  CNT_W: taken-branch flushes.

## Operation
- **Shadow pipeline** registers, updated every cycle:
  - EX slot: `ex_v`, `ex_rd`, `ex_wr`, `ex_br`.
  - WB slot: `wb_v`, `wb_rd`, `wb_wr`, `wb_br`.
- **Flush condition:** `flush = wb_v & wb_br & wb_taken`. `wb_taken` is ignored when the WB slot is not a valid branch.
- **Hazard:**
  - `hz_ex`: `ex_v & ex_wr` and the EX destination equals a used source (rs with `id_uses_rs`, or rt with `id_uses_rt`).
  - `hz_wb`: the same test against the WB slot.
  - `hazard = id_valid & (hz_ex | hz_wb)`.
- **Branch-in-flight:** while `ex_v & ex_br`, the ID instruction is held (treated as a hazard) until the branch reaches WB. At most one unresolved branch is ever downstream of ID.
- **FSM states:**
  - RUN: no stall.
  - STALL: interlock active.
  - FLUSH: the taken-branch cycle.
- **Next-state rules,** in priority order:
  - `flush` → FLUSH.
  - else `hazard` → STALL.
  - else RUN.
- **Outputs in FLUSH:**
  - `pc_write=1`: PC takes the branch target.
  - `ifid_write=1`, `ifid_flush=1`, `idex_bubble=1`, `exwb_bubble=1`.
  - Shadow EX and WB are both cleared.
- **Outputs in STALL:**
  - `pc_write=0`, `ifid_write=0`, `idex_bubble=1`.
  - Shadow EX becomes invalid; shadow WB advances from EX.
- **Outputs in RUN:**
  - All enables are 1 and all flush/bubble outputs are 0.
  - Shadow EX takes the ID tags, gated by `id_valid`; shadow WB takes the EX tags.
- **Outputs are combinational** from the current inputs and shadow state. The registered FSM state feeds only the counters and observability.
- **Counters:**
  - `stall_cnt` increments in every STALL cycle.
  - `flush_cnt` increments on every flush.
  - Both saturate at all-ones and never wrap.

## Timing
- Reset values:
  - State RUN; all shadow valids 0; both counters 0.
  - `pc_write=1`, `ifid_write=1`, all flush/bubble outputs 0.
- Dependent instruction one slot behind its producer:
  - 2 stall cycles without bypass.
  - 1 stall cycle with `HAZARD_WB_BYPASS_EN`.
- Dependent instruction two slots behind: 1 stall cycle without bypass, 0 with it.
- Taken branch: 2 wrong-path instructions squashed. The target instruction is fetched in the cycle after FLUSH.
- Flush and hazard in the same cycle: flush wins and the stalled ID instruction is squashed.
- Reset asserted mid-stall or mid-flush: the next cycle is RUN with empty shadow state, regardless of the other inputs.

## Configuration
- `HAZARD_WB_BYPASS_EN`:
  - **Defined:** the register file is treated as write-before-read, so `hz_wb` is forced to 0 and only EX-slot dependencies stall.
  - **Undefined:** WB-slot dependencies also stall.

## Test plan
- **Back-to-back dependency:**
  - Stimulus: producer writes r5 (`id_writes_rd=1`, `id_rd=5`); next ID instruction reads rs=5.
  - Without bypass: `pc_write`/`ifid_write` low for exactly 2 cycles, `idex_bubble` high for those cycles, `stall_cnt`=2.
  - With bypass: exactly 1 cycle, `stall_cnt`=1.
- **Independent sequence:** r1→r2→r3 with no overlap → zero stalls, `stall_cnt`=0, all flush outputs low.
- **Taken branch:** branch issues, then 2 ALU instructions, then `wb_taken=1` in the branch's WB cycle → one cycle with `ifid_flush`, `idex_bubble`, `exwb_bubble` high; `flush_cnt`=1; shadow valids 0 afterwards.
- **Not-taken branch:** `wb_taken=0` → no flush, `flush_cnt`=0. `wb_taken` pulsed while the WB slot is a non-branch → ignored.
- **Simultaneous events:** hazard on r7 in the same cycle as a taken-branch flush → FLUSH outputs only, `stall_cnt` unchanged.
- **Reset and saturation:**
  - Reset during a 2-cycle stall → next cycle `pc_write=1`, counters 0.
  - `CNT_W`=4 with 20 stall cycles → `stall_cnt`=15.
